// File: rtl/hls_deadlock_watchdog.sv
// rtl/hls_deadlock_watchdog.sv - persistence filter, sticky flag and snapshot report on the HLS monitor block output
module hls_deadlock_watchdog #(
    parameter int N_SIG     = 7,
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 16,
    parameter int EVT_W     = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             block,
    input  logic [N_SIG-1:0] axis_block_sigs,
    input  logic [N_SIG-1:0] inst_idle_sigs,
    input  logic             clear,
    output logic             deadlock,
    output logic             deadlock_pulse,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [EVT_W-1:0] deadlock_count,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [N_SIG-1:0] report_axis,
    output logic [N_SIG-1:0] report_idle
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

    state_t           state, state_n;
    logic [CNT_W-1:0] stall_n;
    logic [EVT_W-1:0] count_n;
    logic [N_SIG-1:0] axis_n, idle_n;
    logic             deadlock_n, pulse_n, rv_n, declare;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            deadlock       <= 1'b0;
            deadlock_pulse <= 1'b0;
            stall_cycles   <= '0;
            deadlock_count <= '0;
            report_valid   <= 1'b0;
            report_axis    <= '0;
            report_idle    <= '0;
        end else begin
            state          <= state_n;
            deadlock       <= deadlock_n;
            deadlock_pulse <= pulse_n;
            stall_cycles   <= stall_n;
            deadlock_count <= count_n;
            report_valid   <= rv_n;
            report_axis    <= axis_n;
            report_idle    <= idle_n;
        end
    end

    always_comb begin
        state_n    = state;
        stall_n    = stall_cycles;
        deadlock_n = deadlock;
        pulse_n    = 1'b0;
        count_n    = deadlock_count;
        rv_n       = report_valid;
        axis_n     = report_axis;
        idle_n     = report_idle;
        declare    = 1'b0;

        // clear overrides everything, including a declaration on the same edge
        if (clear) begin
            state_n    = IDLE;
            stall_n    = '0;
            deadlock_n = 1'b0;
            rv_n       = 1'b0;
            axis_n     = '0;
            idle_n     = '0;
        end else begin
            if (report_valid && report_ready) begin
                rv_n = 1'b0;
            end

            unique case (state)
                IDLE: begin
                    stall_n = '0;
                    if (block) begin
                        stall_n = CNT_ONE;
                        if (THRESHOLD == 1) begin
                            declare = 1'b1;
                        end else begin
                            state_n = SUSPECT;
                        end
                    end
                end
                SUSPECT: begin
                    if (!block) begin
                        state_n = IDLE;
                        stall_n = '0;
                    end else begin
                        stall_n = stall_cycles + CNT_ONE;
                        if (stall_n == THRESH) begin
                            declare = 1'b1;
                        end
                    end
                end
                DEADLOCK: begin
                    // keep measuring the stall, but a released block only freezes the count
                    if (block && (stall_cycles != CNT_MAX)) begin
                        stall_n = stall_cycles + CNT_ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (declare) begin
                state_n    = DEADLOCK;
                deadlock_n = 1'b1;
                pulse_n    = 1'b1;
                rv_n       = 1'b1;
                axis_n     = axis_block_sigs;
                idle_n     = inst_idle_sigs;
                if (deadlock_count != EVT_MAX) begin
                    count_n = deadlock_count + EVT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_hls_deadlock_watchdog.sv
// tb/tb_hls_deadlock_watchdog.sv - directed self-checking bench for hls_deadlock_watchdog
module tb_hls_deadlock_watchdog;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [6:0] axis_sigs, idle_sigs;
    logic       ready;
    logic       b8, c8, b1, c1, b3, c3;

    logic        dl8, p8, rv8;
    logic [15:0] s8;
    logic [7:0]  n8;
    logic [6:0]  ra8, ri8;

    logic        dl1, p1, rv1;
    logic [15:0] s1;
    logic [7:0]  n1;
    logic [6:0]  ra1, ri1;

    logic        dl3, p3, rv3;
    logic [3:0]  s3;
    logic [7:0]  n3;
    logic [6:0]  ra3, ri3;

    int passed = 0;
    int total  = 0;
    logic [13:0] sb_q[$];

    always #5 clock = ~clock;

    hls_deadlock_watchdog #(.N_SIG(7), .THRESHOLD(8), .CNT_W(16), .EVT_W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .block(b8),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs), .clear(c8),
        .deadlock(dl8), .deadlock_pulse(p8), .stall_cycles(s8), .deadlock_count(n8),
        .report_valid(rv8), .report_ready(ready), .report_axis(ra8), .report_idle(ri8)
    );

    hls_deadlock_watchdog #(.N_SIG(7), .THRESHOLD(1), .CNT_W(16), .EVT_W(8)) dut1 (
        .clock(clock), .reset_n(reset_n), .block(b1),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs), .clear(c1),
        .deadlock(dl1), .deadlock_pulse(p1), .stall_cycles(s1), .deadlock_count(n1),
        .report_valid(rv1), .report_ready(ready), .report_axis(ra1), .report_idle(ri1)
    );

    hls_deadlock_watchdog #(.N_SIG(7), .THRESHOLD(3), .CNT_W(4), .EVT_W(8)) dut3 (
        .clock(clock), .reset_n(reset_n), .block(b3),
        .axis_block_sigs(axis_sigs), .inst_idle_sigs(idle_sigs), .clear(c3),
        .deadlock(dl3), .deadlock_pulse(p3), .stall_cycles(s3), .deadlock_count(n3),
        .report_valid(rv3), .report_ready(ready), .report_axis(ra3), .report_idle(ri3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // called while report_valid && report_ready are both high, before the accepting edge
    task automatic sb_pop_check(input string tag);
        logic [13:0] e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_axis"}, 32'(ra8), 32'(e[13:7]));
            check({tag, "_idle"}, 32'(ri8), 32'(e[6:0]));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        axis_sigs = '0; idle_sigs = '0; ready = 1'b0;
        b8 = 0; c8 = 0; b1 = 0; c1 = 0; b3 = 0; c3 = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_deadlock", 32'(dl8), 0);
        check("rst_pulse", 32'(p8), 0);
        check("rst_stall", 32'(s8), 0);
        check("rst_count", 32'(n8), 0);
        check("rst_valid", 32'(rv8), 0);
        check("rst_axis", 32'(ra8), 0);
        reset_n = 1'b1;
        tick();

        // 7-cycle stall is filtered
        b8 = 1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t1_stall", 32'(s8), 32'(k));
            check("t1_deadlock", 32'(dl8), 0);
        end
        b8 = 0;
        tick();
        check("t1_stall_back", 32'(s8), 0);
        check("t1_deadlock_end", 32'(dl8), 0);

        // declaration on the 8th edge
        axis_sigs = 7'h41; idle_sigs = 7'h3E; b8 = 1;
        sb_q.push_back({7'h41, 7'h3E});
        repeat (7) tick();
        check("t2_pre_deadlock", 32'(dl8), 0);
        check("t2_pre_stall", 32'(s8), 7);
        tick();
        check("t2_deadlock", 32'(dl8), 1);
        check("t2_pulse", 32'(p8), 1);
        check("t2_valid", 32'(rv8), 1);
        check("t2_axis", 32'(ra8), 32'h41);
        check("t2_idle", 32'(ri8), 32'h3E);
        check("t2_count", 32'(n8), 1);
        axis_sigs = 7'h7F; idle_sigs = 7'h00;
        tick();
        check("t2_pulse_drop", 32'(p8), 0);
        check("t2_sticky", 32'(dl8), 1);
        check("t2_frozen_axis", 32'(ra8), 32'h41);

        // backpressured report, then handshake
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_valid_hold", 32'(rv8), 1);
            check("t3_axis_stable", 32'(ra8), 32'h41);
            check("t3_idle_stable", 32'(ri8), 32'h3E);
        end
        ready = 1;
        sb_pop_check("t3_hs");
        tick();
        ready = 0;
        check("t3_valid_drop", 32'(rv8), 0);
        check("t3_stall", 32'(s8), 15);
        b8 = 0;
        tick();
        check("t3_sticky_unblocked", 32'(dl8), 1);
        check("t3_stall_hold", 32'(s8), 15);
        repeat (2) tick();
        check("t3_stall_hold2", 32'(s8), 15);

        // clear in DEADLOCK, then second declaration
        c8 = 1;
        tick();
        c8 = 0;
        check("t4_clr_deadlock", 32'(dl8), 0);
        check("t4_clr_pulse", 32'(p8), 0);
        check("t4_clr_stall", 32'(s8), 0);
        check("t4_clr_valid", 32'(rv8), 0);
        check("t4_clr_axis", 32'(ra8), 0);
        check("t4_clr_idle", 32'(ri8), 0);
        check("t4_count_kept", 32'(n8), 1);
        axis_sigs = 7'h15; idle_sigs = 7'h6A; b8 = 1;
        sb_q.push_back({7'h15, 7'h6A});
        repeat (8) tick();
        check("t4_deadlock2", 32'(dl8), 1);
        check("t4_pulse2", 32'(p8), 1);
        check("t4_count2", 32'(n8), 2);
        ready = 1;
        sb_pop_check("t4_hs");
        tick();
        check("t4_valid_drop", 32'(rv8), 0);
        tick();
        check("t4_ready_ignored", 32'(rv8), 0);
        ready = 0;

        // clear and block together: block ignored that edge
        c8 = 1;
        tick();
        c8 = 0;
        check("t4_cb_deadlock", 32'(dl8), 0);
        check("t4_cb_stall", 32'(s8), 0);
        tick();
        check("t4_cb_restart", 32'(s8), 1);
        check("t4_cb_count", 32'(n8), 2);
        b8 = 0;
        tick();
        check("t4_cb_idle", 32'(s8), 0);

        // THRESHOLD=1
        b1 = 1;
        tick();
        check("t5_deadlock", 32'(dl1), 1);
        check("t5_pulse", 32'(p1), 1);
        check("t5_valid", 32'(rv1), 1);
        check("t5_count", 32'(n1), 1);
        c1 = 1;
        tick();
        c1 = 0;
        check("t5_clr_deadlock", 32'(dl1), 0);
        check("t5_clr_valid", 32'(rv1), 0);
        check("t5_clr_pulse", 32'(p1), 0);
        check("t5_clr_count", 32'(n1), 1);
        tick();
        check("t5_redeclare", 32'(dl1), 1);
        check("t5_count2", 32'(n1), 2);

        // CNT_W=4 saturation
        b3 = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3) check("t6_deadlock3", 32'(dl3), 1);
            if (k == 15) check("t6_stall15", 32'(s3), 15);
        end
        check("t6_stall_sat", 32'(s3), 15);
        check("t6_count3", 32'(n3), 1);

        // asynchronous reset mid-SUSPECT and mid-report
        b8 = 1;
        repeat (3) tick();
        check("t7_suspect", 32'(s8), 3);
        check("t7_report_pending", 32'(rv1), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t7_rst_stall8", 32'(s8), 0);
        check("t7_rst_count8", 32'(n8), 0);
        check("t7_rst_deadlock1", 32'(dl1), 0);
        check("t7_rst_valid1", 32'(rv1), 0);
        check("t7_rst_axis1", 32'(ra1), 0);
        check("t7_rst_count1", 32'(n1), 0);
        check("t7_rst_stall3", 32'(s3), 0);
        check("t7_rst_deadlock3", 32'(dl3), 0);
        b8 = 0; b1 = 0; b3 = 0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
